// File: rtl/sdram_arbiter.sv
// Arbitrates periodic auto-refresh, video 8-word burst reads and CPU single-word accesses
// onto one SDRAM controller command port. Optional CPU starvation guard: SDRAM_ARB_STARVE_GUARD_EN.
module sdram_arbiter #(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 16,
   parameter int REFRESH_CYCLES = 780,
   parameter int STARVE_MAX     = 4
) (
   input  logic              clk_sdram,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_rd_valid,
   output logic [DATA_W-1:0] vid_rd_data,
   output logic              vid_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ctl_cmd_valid,
   input  logic              ctl_cmd_ready,
   output logic              ctl_cmd_refresh,
   output logic              ctl_cmd_burst,
   output logic              ctl_cmd_we,
   output logic [ADDR_W-1:0] ctl_cmd_addr,
   output logic [DATA_W-1:0] ctl_cmd_wdata,
   input  logic              ctl_rd_valid,
   input  logic [DATA_W-1:0] ctl_rd_data,
   input  logic              ctl_done
);

   localparam int TMR_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REFRESH_CYCLES - 1);

   if (REFRESH_CYCLES < 2 || STARVE_MAX < 1) begin : g_param_check
      $error("sdram_arbiter: REFRESH_CYCLES must be >= 2 and STARVE_MAX >= 1");
   end

   typedef enum logic [1:0] {IDLE, REFRESH, VIDEO, CPU} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] tmr;
   logic [1:0]       pend, pend_sub, pend_nxt;
   logic             load_ref, load_vid, load_cpu, finish;
   logic             vid_take, cpu_take, cpu_captured;
   logic             cpu_forced;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   logic [SC_W-1:0] starve_cnt;

   assign cpu_forced = cpu_req && (starve_cnt == SC_W'(STARVE_MAX));

   // Counts back-to-back video wins while the CPU is waiting.
   always_ff @(posedge clk_sdram) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (!cpu_req || load_cpu)
            starve_cnt <= '0;
         else if (load_vid && starve_cnt != SC_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + SC_W'(1);
      end
   end
`else
   assign cpu_forced = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      load_ref  = 1'b0;
      load_vid  = 1'b0;
      load_cpu  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (pend != 2'd0) begin
               state_nxt = REFRESH;
               load_ref  = 1'b1;
            end else if (vid_req && !cpu_forced) begin
               state_nxt = VIDEO;
               load_vid  = 1'b1;
            end else if (cpu_req) begin
               state_nxt = CPU;
               load_cpu  = 1'b1;
            end
         end
         default: begin
            // ctl_done only counts once the command has been handed over
            if (!ctl_cmd_valid && ctl_done) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      vid_take = (state == VIDEO) && ctl_rd_valid;
      cpu_take = (state == CPU) && !ctl_cmd_we && ctl_rd_valid && !cpu_captured;
      pend_sub = pend - 2'((state == REFRESH) && finish);
      pend_nxt = pend_sub;
      if (tmr == '0 && pend_sub != 2'd3)
         pend_nxt = pend_sub + 2'd1;
   end

   always_ff @(posedge clk_sdram) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk_sdram) begin
      if (reset) begin
         tmr             <= TMR_LOAD;
         pend            <= 2'd0;
         ctl_cmd_valid   <= 1'b0;
         ctl_cmd_refresh <= 1'b0;
         ctl_cmd_burst   <= 1'b0;
         ctl_cmd_we      <= 1'b0;
         ctl_cmd_addr    <= '0;
         ctl_cmd_wdata   <= '0;
         vid_rd_valid    <= 1'b0;
         vid_rd_data     <= '0;
         vid_done        <= 1'b0;
         cpu_ack         <= 1'b0;
         cpu_rdata       <= '0;
         cpu_captured    <= 1'b0;
      end else begin
         tmr  <= (tmr == '0) ? TMR_LOAD : tmr - TMR_W'(1);
         pend <= pend_nxt;

         if (load_ref || load_vid || load_cpu)
            ctl_cmd_valid <= 1'b1;
         else if (ctl_cmd_ready)
            ctl_cmd_valid <= 1'b0;

         // Command fields are captured once at grant and left alone until the next grant
         if (load_ref) begin
            ctl_cmd_refresh <= 1'b1;
            ctl_cmd_burst   <= 1'b0;
            ctl_cmd_we      <= 1'b0;
            ctl_cmd_addr    <= '0;
            ctl_cmd_wdata   <= '0;
         end else if (load_vid) begin
            ctl_cmd_refresh <= 1'b0;
            ctl_cmd_burst   <= 1'b1;
            ctl_cmd_we      <= 1'b0;
            ctl_cmd_addr    <= vid_addr;
            ctl_cmd_wdata   <= '0;
         end else if (load_cpu) begin
            ctl_cmd_refresh <= 1'b0;
            ctl_cmd_burst   <= 1'b0;
            ctl_cmd_we      <= cpu_we;
            ctl_cmd_addr    <= cpu_addr;
            ctl_cmd_wdata   <= cpu_wdata;
         end

         vid_rd_valid <= vid_take;
         if (vid_take)
            vid_rd_data <= ctl_rd_data;

         if (load_cpu)
            cpu_captured <= 1'b0;
         else if (cpu_take)
            cpu_captured <= 1'b1;
         if (cpu_take)
            cpu_rdata <= ctl_rd_data;

         vid_done <= finish && (state == VIDEO);
         cpu_ack  <= finish && (state == CPU);
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic against a cycle-level
// behavioural model of the arbitration rules; the bench also plays the SDRAM controller.
module tb_sdram_arbiter;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam int RC     = 16;
   localparam int SM     = 4;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk_sdram = 1'b0;
   logic              reset;
   logic              vid_req, vid_rd_valid, vid_done;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_rd_data;
   logic              cpu_req, cpu_we, cpu_ack;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              ctl_cmd_valid, ctl_cmd_ready, ctl_cmd_refresh, ctl_cmd_burst, ctl_cmd_we;
   logic [ADDR_W-1:0] ctl_cmd_addr;
   logic [DATA_W-1:0] ctl_cmd_wdata;
   logic              ctl_rd_valid, ctl_done;
   logic [DATA_W-1:0] ctl_rd_data;

   always #5 clk_sdram = ~clk_sdram;

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_CYCLES(RC), .STARVE_MAX(SM)) dut (
      .clk_sdram(clk_sdram), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rd_valid(vid_rd_valid),
      .vid_rd_data(vid_rd_data), .vid_done(vid_done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready),
      .ctl_cmd_refresh(ctl_cmd_refresh), .ctl_cmd_burst(ctl_cmd_burst), .ctl_cmd_we(ctl_cmd_we),
      .ctl_cmd_addr(ctl_cmd_addr), .ctl_cmd_wdata(ctl_cmd_wdata),
      .ctl_rd_valid(ctl_rd_valid), .ctl_rd_data(ctl_rd_data), .ctl_done(ctl_done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: owner 0=none 1=refresh 2=video 3=cpu; m_e counts edges since reset.
   int                m_e, m_pend, m_owner, m_starve;
   bit                m_valid, m_ref, m_burst, m_we, m_cap, m_vv, m_done, m_ack;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_vdata, m_rdata;

   always @(posedge clk_sdram) begin : model
      int g;
      int p;
      bit dec;
      if (reset) begin
         m_e = 0; m_pend = 0; m_owner = 0; m_starve = 0;
         m_valid = 0; m_ref = 0; m_burst = 0; m_we = 0; m_cap = 0;
         m_vv = 0; m_done = 0; m_ack = 0;
         m_addr = '0; m_wdata = '0; m_vdata = '0; m_rdata = '0;
      end else begin
         m_e++;
         m_vv = 0; m_done = 0; m_ack = 0; dec = 0;
         if (m_owner == 0) begin
            if (m_pend > 0) g = 1;
            else if (vid_req && !(GUARD && cpu_req && m_starve == SM)) g = 2;
            else if (cpu_req) g = 3;
            else g = 0;
            if (GUARD) begin
               if (!cpu_req || g == 3) m_starve = 0;
               else if (g == 2 && m_starve < SM) m_starve++;
            end
            m_owner = g;
            m_valid = (g != 0);
            m_ref   = (g == 1);
            m_burst = (g == 2);
            m_we    = (g == 3) && cpu_we;
            if (g == 2) m_addr = vid_addr;
            if (g == 3) begin
               m_addr = cpu_addr; m_wdata = cpu_wdata; m_cap = 0;
            end
         end else begin
            if (m_owner == 2 && ctl_rd_valid) begin
               m_vv = 1; m_vdata = ctl_rd_data;
            end
            if (m_owner == 3 && !m_we && !m_cap && ctl_rd_valid) begin
               m_rdata = ctl_rd_data; m_cap = 1;
            end
            if (m_valid) begin
               if (ctl_cmd_ready) m_valid = 0;
            end else if (ctl_done) begin
               dec = (m_owner == 1); m_done = (m_owner == 2); m_ack = (m_owner == 3);
               m_owner = 0;
            end
         end
         p = m_pend - int'(dec);
         if ((m_e % RC) == 0 && p < 3) p++;
         m_pend = p;
      end
   end

   bit chk_en = 0;

   always @(negedge clk_sdram) begin
      if (chk_en) begin
         chk("cmd_valid", 64'(ctl_cmd_valid), 64'(m_valid));
         if (m_valid) begin
            chk("cmd_flags", 64'({ctl_cmd_refresh, ctl_cmd_burst, ctl_cmd_we}), 64'({m_ref, m_burst, m_we}));
            if (m_owner != 1) chk("cmd_addr", 64'(ctl_cmd_addr), 64'(m_addr));
            if (m_owner == 3 && m_we) chk("cmd_wdata", 64'(ctl_cmd_wdata), 64'(m_wdata));
         end
         chk("vid_rd_valid", 64'(vid_rd_valid), 64'(m_vv));
         if (m_vv) chk("vid_rd_data", 64'(vid_rd_data), 64'(m_vdata));
         chk("vid_done", 64'(vid_done), 64'(m_done));
         chk("cpu_ack", 64'(cpu_ack), 64'(m_ack));
         chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata));
      end
   end

   // Stimulus and controller-responder state
   bit                rnd = 0;
   bit                hold_reqs = 0;
   int                ready_delay = 0;
   logic [DATA_W-1:0] rd_word = '0;
   bit                c_busy = 0;
   bit                c_burst = 0;
   int                c_words = 0;
   int                c_vcnt = 0;

   task automatic tick();
      bit acc, k_burst, k_ref, k_we, rst_edge, idle_now;
      acc      = ctl_cmd_valid && ctl_cmd_ready;
      k_burst  = ctl_cmd_burst;
      k_ref    = ctl_cmd_refresh;
      k_we     = ctl_cmd_we;
      rst_edge = reset;
      @(posedge clk_sdram);
      #1;
      if (rst_edge) begin
         c_busy = 0; c_vcnt = 0;
      end else if (acc) begin
         c_busy  = 1; c_vcnt = 0; c_burst = k_burst;
         c_words = k_burst ? 8 : ((k_ref || k_we) ? 0 : 1);
      end
      if (!hold_reqs) begin
         if (vid_done) vid_req = 0;
         if (cpu_ack) cpu_req = 0;
      end
      if (rnd) begin
         if (!vid_req && $urandom_range(0, 5) == 0) vid_req = 1;
         if (!cpu_req && $urandom_range(0, 4) == 0) cpu_req = 1;
         vid_addr  = ADDR_W'($urandom);
         cpu_addr  = ADDR_W'($urandom);
         cpu_wdata = DATA_W'($urandom);
         cpu_we    = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 299) == 0);
      end
      idle_now      = !c_busy && !ctl_cmd_valid;
      ctl_cmd_ready = 0;
      ctl_rd_valid  = 0;
      ctl_done      = 0;
      ctl_rd_data   = DATA_W'($urandom);
      if (ctl_cmd_valid && !c_busy) begin
         c_vcnt++;
         ctl_cmd_ready = rnd ? ($urandom_range(0, 2) == 0) : (c_vcnt > ready_delay);
      end
      if (c_busy) begin
         if (c_words > 0) begin
            if (!rnd || $urandom_range(0, 3) != 0) begin
               ctl_rd_valid = 1;
               if (!rnd) ctl_rd_data = rd_word;
               c_words--;
            end
         end else begin
            if (rnd && !c_burst && $urandom_range(0, 3) == 0) ctl_rd_valid = 1;
            if (!rnd || $urandom_range(0, 2) == 0) begin
               ctl_done = 1; c_busy = 0;
            end
         end
      end else if (rnd && idle_now && $urandom_range(0, 7) == 0) begin
         ctl_rd_valid = 1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_zero_cmd"},
          64'({ctl_cmd_valid, ctl_cmd_refresh, ctl_cmd_burst, ctl_cmd_we, ctl_cmd_addr, ctl_cmd_wdata}), 64'(0));
      chk({tag, "_zero_rsp"},
          64'({vid_rd_valid, vid_rd_data, vid_done, cpu_ack, cpu_rdata}), 64'(0));
   endtask

   // With no requests, the first refresh command shows at edge 17 after the reset edge, then 16 later.
   task automatic ref_timing(input string tag);
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (k < 17) begin
            chk({tag, "_quiet"}, 64'(ctl_cmd_valid), 64'(0));
            chk({tag, "_no_done"}, 64'(vid_done), 64'(0));
         end
         if (k == 17 || k == 33)
            chk({tag, "_refresh"}, 64'({ctl_cmd_valid, ctl_cmd_refresh}), 64'(2'b11));
      end
   endtask

   initial begin
      bit got, pv, cpu_done;
      int n_grant, words, vdone, cnt;
      int kinds [6];
      reset = 1; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ctl_cmd_ready = 0; ctl_rd_valid = 0; ctl_rd_data = '0; ctl_done = 0;

      tick();
      chk_en = 1;
      reset  = 0;
      chk_zero("reset");
      ref_timing("ref");
      repeat (4) tick();

      // CPU read with a slow controller
      ready_delay = 3; rd_word = 16'hBEEF;
      cpu_we = 0; cpu_addr = 24'h000123; cpu_req = 1;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         tick();
         if (ctl_cmd_valid && !ctl_cmd_refresh) begin
            chk("cpu_rd_we", 64'(ctl_cmd_we), 64'(0));
            chk("cpu_rd_addr", 64'(ctl_cmd_addr), 64'(24'h000123));
         end
         if (cpu_ack) begin
            got = 1;
            chk("cpu_rd_data", 64'(cpu_rdata), 64'(16'hBEEF));
         end
      end
      chk("cpu_ack_seen", 64'(got), 64'(1));
      ready_delay = 0;
      repeat (3) tick();
      chk("cpu_rdata_hold", 64'(cpu_rdata), 64'(16'hBEEF));

      // Simultaneous video and CPU-write requests
      vid_addr = 24'h0ABCD0; cpu_we = 1; cpu_addr = 24'h000456; cpu_wdata = 16'h1234;
      rd_word = 16'h5A5A; vid_req = 1; cpu_req = 1;
      n_grant = 0; words = 0; vdone = 0; cpu_done = 0; pv = ctl_cmd_valid;
      for (int i = 0; i < 300 && !cpu_done; i++) begin
         tick();
         if (ctl_cmd_valid && !pv && !ctl_cmd_refresh) begin
            if (n_grant == 0) chk("order_first_video", 64'(ctl_cmd_burst), 64'(1));
            else if (n_grant == 1) begin
               chk("order_then_cpu_write", 64'({ctl_cmd_burst, ctl_cmd_we}), 64'(2'b01));
               chk("order_words_first", 64'(words), 64'(8));
               chk("order_vid_done_first", 64'(vdone), 64'(1));
            end
            n_grant++;
         end
         pv = ctl_cmd_valid;
         if (vid_rd_valid) begin
            words++;
            chk("burst_word", 64'(vid_rd_data), 64'(16'h5A5A));
         end
         if (vid_done) vdone++;
         if (cpu_ack) cpu_done = 1;
      end
      chk("cpu_write_acked", 64'(cpu_done), 64'(1));
      chk("burst_word_count", 64'(words), 64'(8));
      chk("vid_done_once", 64'(vdone), 64'(1));

      // Continuous video pressure with a waiting CPU
      reset = 1;
      tick();
      reset = 0;
      hold_reqs = 1; vid_req = 1; cpu_req = 1; cpu_we = 0;
      n_grant = 0; pv = 0;
      for (int j = 0; j < 6; j++) kinds[j] = 0;
      for (int i = 0; i < 800 && n_grant < 6; i++) begin
         tick();
         if (ctl_cmd_valid && !pv && !ctl_cmd_refresh) begin
            kinds[n_grant] = ctl_cmd_burst ? 2 : 3;
            n_grant++;
         end
         pv = ctl_cmd_valid;
      end
      chk("starve_grant_count", 64'(n_grant), 64'(6));
      for (int j = 0; j < 6; j++)
         chk($sformatf("starve_grant%0d", j), 64'(kinds[j]), 64'((GUARD && j == 4) ? 3 : 2));
      hold_reqs = 0; vid_req = 0; cpu_req = 0;
      repeat (40) tick();

      // Reset in the middle of a burst
      vid_addr = 24'h000800; rd_word = 16'hC0DE; vid_req = 1; cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         tick();
         if (vid_rd_valid) cnt++;
      end
      chk("abort_words", 64'(cnt), 64'(3));
      reset = 1; vid_req = 0;
      tick();
      reset = 0;
      chk_zero("abort");
      ref_timing("abort");

      // Randomized traffic
      rnd = 1;
      repeat (3000) tick();
      rnd = 0; reset = 0; vid_req = 0; cpu_req = 0;
      repeat (60) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, word address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, data width.
REQ-003 The block SHALL have parameter REFRESH_CYCLES, default 780, clk_sdram cycles between refresh requests (7.8 us at 100 MHz).
REQ-004 The block SHALL have parameter STARVE_MAX, default 4, the number of consecutive video grants allowed before the CPU is forced in (used only with the guard enabled).
REQ-005 Ports SHALL be as follows.
- clk_sdram  in  1  sole clock (100 MHz controller domain).
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  video burst-read request; held until vid_done.
- vid_addr  in  ADDR_W  burst start address.
- vid_rd_valid  out  1  one burst word valid.
- vid_rd_data  out  DATA_W  burst word.
- vid_done  out  1  one-cycle pulse when the burst is complete.
- cpu_req  in  1  CPU single-word request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack.
- ctl_cmd_valid  out  1  command to the SDRAM controller.
- ctl_cmd_ready  in  1  controller accepts the command.
- ctl_cmd_refresh  out  1  command is an auto-refresh.
- ctl_cmd_burst  out  1  command is an 8-word burst read.
- ctl_cmd_we  out  1  command is a write.
- ctl_cmd_addr  out  ADDR_W  command address.
- ctl_cmd_wdata  out  DATA_W  command write data.
- ctl_rd_valid  in  1  read word from the controller.
- ctl_rd_data  in  DATA_W  read data from the controller.
- ctl_done  in  1  pulse when the controller has finished the command.

Function
REQ-006 The FSM SHALL have states IDLE, REFRESH, VIDEO and CPU.
REQ-007 Refresh timer: counts down from REFRESH_CYCLES-1; at 0 it reloads and increments a 2-bit pending count that saturates at 3.
REQ-008 Priority in IDLE: pending refresh > vid_req > cpu_req; the grant is registered, so ctl_cmd_valid rises the cycle after the IDLE decision.
REQ-009 Command fields SHALL be latched at grant and held stable while ctl_cmd_valid=1; ctl_cmd_valid drops the cycle after ctl_cmd_valid & ctl_cmd_ready.
REQ-010 After command acceptance the FSM SHALL wait for ctl_done, then return to IDLE; at least one IDLE cycle SHALL separate transactions.
REQ-011 REFRESH: ctl_cmd_refresh=1, other command flags 0; ctl_done decrements the pending count by 1.
REQ-012 VIDEO: ctl_cmd_burst=1; each ctl_rd_valid SHALL be registered to vid_rd_valid/vid_rd_data with 1-cycle latency; vid_done SHALL pulse one cycle after ctl_done.
REQ-013 CPU: ctl_cmd_we=cpu_we; on a read, the first ctl_rd_data SHALL be captured into cpu_rdata; cpu_ack SHALL pulse one cycle after ctl_done; cpu_rdata SHALL hold until the next CPU read.
REQ-014 ctl_rd_valid outside VIDEO/CPU SHALL be ignored; vid_rd_valid SHALL never assert outside VIDEO.
REQ-015 Timer expiry coinciding with a grant SHALL NOT alter the grant; the pending refresh is served at the next IDLE.
REQ-016 Requester inputs changing after grant SHALL have no effect on the current transaction.

Reset
REQ-017 Reset SHALL force IDLE, clear all outputs and cpu_rdata/vid_rd_data to 0, clear the pending count and reload the timer, including mid-transaction.

Configuration
REQ-018 With SDRAM_ARB_STARVE_GUARD_EN defined, a counter SHALL count consecutive video grants; when it equals STARVE_MAX and cpu_req=1, CPU SHALL win over video (refresh still first); the counter clears on a CPU grant or on an IDLE decision with cpu_req=0.
REQ-019 Without SDRAM_ARB_STARVE_GUARD_EN, strict priority SHALL apply and the counter SHALL not exist.

Verification
REQ-020 REFRESH_CYCLES=16, reset released at cycle 0, no requests -> ctl_cmd_valid & ctl_cmd_refresh at cycle 16, then every 16 cycles.
REQ-021 cpu_req read at 0x000123 with controller returning 0xBEEF -> cpu_ack pulse with cpu_rdata=0xBEEF; ctl_cmd_we=0 and ctl_cmd_addr=0x000123 held until ready.
REQ-022 vid_req and cpu_req asserted in the same IDLE cycle -> VIDEO granted first with 8 vid_rd_valid pulses and vid_done, then the CPU write is issued.
REQ-023 vid_req held continuously, cpu_req high, guard enabled, STARVE_MAX=4 -> the 5th grant goes to CPU; guard disabled -> CPU is never granted.
REQ-024 reset asserted for 1 cycle mid-burst after 3 words -> next cycle IDLE, all outputs 0, no vid_done, refresh timer restarts.
